id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage MIPS pipeline, directly downstream of the register file.
- Drives the register-file read addresses from the IF/ID instruction.
- Captures the two read operands, the sign-extended immediate and the decoded control bundle into the ID/EX pipeline register.
- Detects load-use hazards, inserting exactly one bubble while stalling upstream, and keeps a saturating stall counter for performance monitoring.

Parameters:
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  IF/ID holds a live instruction
- if_instr  in  32  IF/ID instruction word
- if_pc4  in  32  IF/ID PC+4
- ctl_regwrite, ctl_memread, ctl_memwrite, ctl_memtoreg, ctl_alusrc, ctl_regdst  in  1 each  decoded control for if_instr
- ctl_aluop  in  2  decoded ALU op class
- hold  in  1  global freeze (e.g. memory wait); register keeps contents
- flush  in  1  squash the instruction in IF/ID (taken branch/jump)
- rf_read1  out  5  register-file read address A = if_instr[25:21]
- rf_read2  out  5  register-file read address B = if_instr[20:16]
- rf_data1, rf_data2  in  32  operands returned combinationally by the register file (write-back bypass already applied there)
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX stage holds a live instruction
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst  out  1 each  registered control
- ex_aluop  out  2  registered ALU op class
- ex_rs, ex_rt, ex_rd  out  5 each  registered instr[25:21], [20:16], [15:11]
- ex_data1, ex_data2  out  32  registered operands
- ex_imm  out  32  registered sign-extension of instr[15:0]
- ex_pc4  out  32  registered PC+4
- stall_cnt  out  CNT_W  count of hazard bubbles inserted, saturating

Behaviour:
- Reset (async, rst=1): every registered output, including stall_cnt, is 0. stall is 0 while in reset.
- rf_read1/rf_read2 are purely combinational slices of if_instr, with no gating.
- Hazard term: haz = if_valid & ex_valid & ex_memread & (ex_rt != 0) & (ex_rt == if_instr[25:21] | ex_rt == if_instr[20:16]).
- stall = haz & ~flush (combinational). A flushed instruction never stalls.
- Per-edge update priority, highest first:
  - hold=1: all ID/EX fields and stall_cnt unchanged. Upstream must keep flush stable until hold drops.
  - flush=1: load a bubble.
  - haz=1: load a bubble and increment stall_cnt.
  - otherwise: load the instruction.
- Bubble: ex_valid, all ex_ control bits and ex_aluop are 0; ex_rs/rt/rd, ex_data1/2, ex_imm and ex_pc4 are 0.
- Load: ex_valid=if_valid.
  - Control bits load only when if_valid=1; otherwise they are 0, so an invalid slot never writes.
  - Data, immediate, register specifiers and pc4 are captured as presented.
- Latency: one cycle from IF/ID to EX outputs.
- Load-use penalty is exactly one bubble. The bubble clears ex_memread, so haz drops the next cycle and the dependent instruction then issues with the load result supplied by the downstream forwarding path.
- Back-to-back loads with a dependency produce one bubble per load-use pair, never two consecutive bubbles for the same pair.
- stall_cnt saturates at 2^CNT_W-1, with no wrap.
- rst asserted mid-stall: outputs go to 0 immediately. The first edge after release behaves as from reset (ex_memread=0, so no stall).

Test Plan:
- Reset: assert rst asynchronously mid-cycle with outputs non-zero -> all ex_* and stall_cnt read 0 before the next edge, and stall=0.
- Pass-through: if_instr=0x012A4020 (add $8,$9,$10), rf_data1=0x11, rf_data2=0x22, ctl_regwrite=1, regdst=1 -> next cycle ex_rs=9, ex_rt=10, ex_rd=8, ex_data1=0x11, ex_data2=0x22, ex_imm=0x00004020, ex_valid=1.
- Load-use: lw $8,0($9) followed by add $10,$8,$11 -> stall=1 for exactly one cycle, one bubble (ex_valid=0) enters EX, add issues next cycle, stall_cnt=1.
- $zero and negative immediate: lw $0 then use of $0 -> no stall. Immediate 0x8000 -> ex_imm=0xFFFF8000.
- Flush vs stall: hazard condition present with flush=1 -> stall=0, bubble loaded, stall_cnt unchanged.
- Hold and saturation: hold=1 for 3 cycles during a hazard -> EX contents and stall_cnt frozen. With CNT_W=2, five hazards -> stall_cnt stays 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: register-file address drive, operand/immediate capture,
// load-use hazard detection with single-bubble insertion and saturating stall counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc4,
  input  logic             ctl_regwrite,
  input  logic             ctl_memread,
  input  logic             ctl_memwrite,
  input  logic             ctl_memtoreg,
  input  logic             ctl_alusrc,
  input  logic             ctl_regdst,
  input  logic [1:0]       ctl_aluop,
  input  logic             hold,
  input  logic             flush,
  output logic [4:0]       rf_read1,
  output logic [4:0]       rf_read2,
  input  logic [31:0]      rf_data1,
  input  logic [31:0]      rf_data2,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic             ex_regdst,
  output logic [1:0]       ex_aluop,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_data1,
  output logic [31:0]      ex_data2,
  output logic [31:0]      ex_imm,
  output logic [31:0]      ex_pc4,
  output logic [CNT_W-1:0] stall_cnt
);

  logic        haz;
  logic        bubble;
  logic [31:0] imm_sext;

  assign rf_read1 = if_instr[25:21];
  assign rf_read2 = if_instr[20:16];
  assign imm_sext = {{16{if_instr[15]}}, if_instr[15:0]};

  // A load in EX whose destination is a source of the ID instruction; $zero never hazards.
  assign haz = if_valid & ex_valid & ex_memread & (ex_rt != 5'd0) &
               ((ex_rt == if_instr[25:21]) | (ex_rt == if_instr[20:16]));
  assign stall  = haz & ~flush;
  assign bubble = flush | haz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      ex_data1    <= 32'd0;
      ex_data2    <= 32'd0;
      ex_imm      <= 32'd0;
      ex_pc4      <= 32'd0;
      stall_cnt   <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_regdst   <= 1'b0;
        ex_aluop    <= 2'b00;
        ex_rs       <= 5'd0;
        ex_rt       <= 5'd0;
        ex_rd       <= 5'd0;
        ex_data1    <= 32'd0;
        ex_data2    <= 32'd0;
        ex_imm      <= 32'd0;
        ex_pc4      <= 32'd0;
      end else begin
        // Control is gated by if_valid so an empty slot can never write state.
        ex_valid    <= if_valid;
        ex_regwrite <= if_valid & ctl_regwrite;
        ex_memread  <= if_valid & ctl_memread;
        ex_memwrite <= if_valid & ctl_memwrite;
        ex_memtoreg <= if_valid & ctl_memtoreg;
        ex_alusrc   <= if_valid & ctl_alusrc;
        ex_regdst   <= if_valid & ctl_regdst;
        ex_aluop    <= if_valid ? ctl_aluop : 2'b00;
        ex_rs       <= if_instr[25:21];
        ex_rt       <= if_instr[20:16];
        ex_rd       <= if_instr[15:11];
        ex_data1    <= rf_data1;
        ex_data2    <= rf_data2;
        ex_imm      <= imm_sext;
        ex_pc4      <= if_pc4;
      end
      if (!flush && haz && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
